// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: state encodings, default width,
// and bit-counter sizing.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell, only built when SERIAL_SUB_ADD_MODE_EN is defined.
`ifdef SERIAL_SUB_ADD_MODE_EN
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | ((a ^ b) & cin);

endmodule
`endif

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin, built from two half-subtractor stages
// whose borrows are ORed.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  logic d1, b1, b2;

  assign d1     = x ^ y;
  assign b1     = ~x & y;
  assign diff   = d1 ^ bin;
  assign b2     = ~d1 & bin;
  assign borrow = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) with start/busy/done handshake.
// Optional add mode and `mode` port when SERIAL_SUB_ADD_MODE_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             bflop;
  logic             a_msb, b_msb;
  logic             fs_d, fs_b;
  logic             cell_d, cell_b;
  logic             ovf_next;

  full_subtractor u_fs (
    .x      (a_sh[0]),
    .y      (b_sh[0]),
    .bin    (bflop),
    .diff   (fs_d),
    .borrow (fs_b)
  );

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic mode_q;
  logic fa_s, fa_c;

  fullAdder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (bflop),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // The borrow flop doubles as the carry flop in add mode.
  assign cell_d   = mode_q ? fa_s : fs_d;
  assign cell_b   = mode_q ? fa_c : fs_b;
  assign ovf_next = mode_q ? ((a_msb == b_msb) & (res[WIDTH-1] != a_msb))
                           : ((a_msb != b_msb) & (res[WIDTH-1] != a_msb));
`else
  assign cell_d   = fs_d;
  assign cell_b   = fs_b;
  assign ovf_next = (a_msb != b_msb) & (res[WIDTH-1] != a_msb);
`endif

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      bflop    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            bflop <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q <= mode;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= {cell_d, res[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          bflop <= cell_b;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          // Flags are published one edge after the last shift, so done lines up with them.
          done     <= 1'b1;
          diff     <= res;
          borrow   <= bflop;
          overflow <= ovf_next;
          zero     <= (res == '0);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); add-mode cases
// are included when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow, overflow, zero;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         mode;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode     (mode),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Presents operands with start for exactly one edge; returns at the negedge after that edge.
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = negedges after the accepting edge until done is seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff); end
    total++; if ({borrow, overflow, zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {borrow, overflow, zero}); end
    rst = 1'b0;
  endtask

  task automatic test_subtract;
    logic [W-1:0] va [6] = '{8'h35, 8'h12, 8'h80, 8'h5A, 8'h00, 8'h7F};
    logic [W-1:0] vb [6] = '{8'h12, 8'h35, 8'h01, 8'h5A, 8'h01, 8'hFF};
    logic [W-1:0] vd [6] = '{8'h23, 8'hDD, 8'h7F, 8'h00, 8'hFF, 8'h80};
    logic [2:0]   vf [6] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100, 3'b110};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i]);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sub_busy[%0d] got=%b want=1", i, busy); end
      a = ~va[i]; b = ~vb[i];
      wait_done(cyc);
      total++; if (cyc != W + 1) begin bad++; $display("FAIL sub_latency[%0d] got=%0d want=%0d", i, cyc, W + 1); end
      total++; if (diff !== vd[i]) begin bad++; $display("FAIL sub_diff[%0d] got=%h want=%h", i, diff, vd[i]); end
      total++; if ({borrow, overflow, zero} !== vf[i]) begin bad++; $display("FAIL sub_flags[%0d] got=%b want=%b", i, {borrow, overflow, zero}, vf[i]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sub_busy_done[%0d] got=%b want=0", i, busy); end
      if (i == 0) begin
        repeat (3) @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single_cycle got=%b want=0", done); end
        total++; if (diff !== 8'h23) begin bad++; $display("FAIL diff_hold got=%h want=23", diff); end
      end
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic [W-1:0] seen = '0;
    launch(8'hFF, 8'h01);
    total++; if (diff !== 8'h80) begin bad++; $display("FAIL diff_not_cleared got=%h want=80", diff); end
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h00;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55;
    if (done) begin pulses++; seen = diff; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin pulses++; seen = diff; end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    total++; if (seen !== 8'hFE) begin bad++; $display("FAIL ignore_diff got=%h want=FE", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%b want=0", busy); end
  endtask

  task automatic test_done_cycle_start;
    launch(8'h10, 8'h01);
    repeat (8) @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL done_state_view got=%b want=00", {busy, done}); end
    start = 1'b1; a = 8'h33; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_cycle_pulse got=%b want=1", done); end
    total++; if (diff !== 8'h0F) begin bad++; $display("FAIL done_cycle_diff got=%h want=0F", diff); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_cycle_start_ignored got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(8'h20, 8'h30);
    wait_done(cyc);
    total++; if (diff !== 8'hF0 || borrow !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b want=F0/1", diff, borrow); end
    start = 1'b1; a = 8'h09; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    total++; if (diff !== 8'hF0) begin bad++; $display("FAIL b2b_hold got=%h want=F0", diff); end
    wait_done(cyc);
    total++; if (cyc != W + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, W + 1); end
    total++; if (diff !== 8'h06 || borrow !== 1'b0) begin bad++; $display("FAIL b2b_second got=%h/%b want=06/0", diff, borrow); end
  endtask

  task automatic test_reset_mid_shift;
    int pulses = 0;
    int cyc;
    launch(8'h44, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_busy_done got=%b want=00", {busy, done}); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL midrst_diff got=%h want=00", diff); end
    total++; if ({borrow, overflow, zero} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b want=000", {borrow, overflow, zero}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", pulses); end
    launch(8'h44, 8'h11);
    wait_done(cyc);
    total++; if (cyc != W + 1) begin bad++; $display("FAIL midrst_recover_latency got=%0d want=%0d", cyc, W + 1); end
    total++; if (diff !== 8'h33) begin bad++; $display("FAIL midrst_recover_diff got=%h want=33", diff); end
  endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
  task automatic test_add_mode;
    int cyc;
    mode = 1'b1;
    launch(8'h7F, 8'h01);
    mode = 1'b0;
    wait_done(cyc);
    total++; if (diff !== 8'h80) begin bad++; $display("FAIL add_diff0 got=%h want=80", diff); end
    total++; if ({borrow, overflow, zero} !== 3'b010) begin bad++; $display("FAIL add_flags0 got=%b want=010", {borrow, overflow, zero}); end
    mode = 1'b1;
    launch(8'hFF, 8'h01);
    mode = 1'b0;
    wait_done(cyc);
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL add_diff1 got=%h want=00", diff); end
    total++; if ({borrow, overflow, zero} !== 3'b101) begin bad++; $display("FAIL add_flags1 got=%b want=101", {borrow, overflow, zero}); end
  endtask
`endif

  initial begin
    test_reset;
    test_subtract;
    test_ignore_start;
    test_done_cycle_start;
    test_back_to_back;
    test_reset_mid_shift;
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_add_mode;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
